// File: rtl/axi_burst_splitter.sv
// Splits AXI4 write-address bursts into AXI3-sized sub-bursts of at most 2^OUT_LEN_WIDTH beats.
// Optional macro AXI_SPLIT_4K_BOUNDARY_EN also cuts INCR sub-bursts at 4 KB boundaries.
module axi_burst_splitter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int IN_LEN_WIDTH  = 8,
  parameter int OUT_LEN_WIDTH = 4,
  parameter int ID_WIDTH      = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ID_WIDTH-1:0]      S_AXI_awid,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_awaddr,
  input  logic [IN_LEN_WIDTH-1:0]  S_AXI_awlen,
  input  logic [2:0]               S_AXI_awsize,
  input  logic [1:0]               S_AXI_awburst,
  input  logic [1:0]               S_AXI_awlock,
  input  logic [3:0]               S_AXI_awcache,
  input  logic [2:0]               S_AXI_awprot,
  input  logic                     S_AXI_awvalid,
  output logic                     S_AXI_awready,
  output logic [ID_WIDTH-1:0]      M_AXI_awid,
  output logic [ADDR_WIDTH-1:0]    M_AXI_awaddr,
  output logic [OUT_LEN_WIDTH-1:0] M_AXI_awlen,
  output logic [2:0]               M_AXI_awsize,
  output logic [1:0]               M_AXI_awburst,
  output logic [1:0]               M_AXI_awlock,
  output logic [3:0]               M_AXI_awcache,
  output logic [2:0]               M_AXI_awprot,
  output logic                     M_AXI_awvalid,
  input  logic                     M_AXI_awready,
  output logic                     M_Last_Sub,
  output logic                     Busy
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  localparam int RW = IN_LEN_WIDTH + 1;
  localparam logic [RW-1:0] MAXB = RW'(2**OUT_LEN_WIDTH);
  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;

  logic [0:0]            state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [1:0]            lock_q;
  logic [3:0]            cache_q;
  logic [2:0]            prot_q;
  logic [RW-1:0]         rem_q;
  logic [RW-1:0]         beats;
  logic                  issue;
  logic                  last;

  // Beats carried by the sub-burst currently on the bus.
`ifdef AXI_SPLIT_4K_BOUNDARY_EN
  logic [12:0] room;
  always_comb begin
    beats = (rem_q > MAXB) ? MAXB : rem_q;
    room  = (13'h1000 - {1'b0, addr_q[11:0]}) >> size_q;
    if (room == '0) room = 13'd1;
    if (burst_q == B_INCR && 32'(room) < 32'(beats)) beats = RW'(room);
  end
`else
  always_comb begin
    beats = (rem_q > MAXB) ? MAXB : rem_q;
  end
`endif

  assign issue = (state == ISSUE);
  assign last  = (rem_q == beats);

  assign S_AXI_awready = !issue && !ARESET;
  assign M_AXI_awvalid = issue && !ARESET;
  assign M_AXI_awlen   = issue ? OUT_LEN_WIDTH'(beats - RW'(1)) : '0;
  assign M_Last_Sub    = issue && last;
  assign Busy          = issue;
  assign M_AXI_awid    = id_q;
  assign M_AXI_awaddr  = addr_q;
  assign M_AXI_awsize  = size_q;
  assign M_AXI_awburst = burst_q;
  assign M_AXI_awlock  = lock_q;
  assign M_AXI_awcache = cache_q;
  assign M_AXI_awprot  = prot_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      lock_q  <= '0;
      cache_q <= '0;
      prot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (S_AXI_awvalid) begin
            state   <= ISSUE;
            id_q    <= S_AXI_awid;
            addr_q  <= S_AXI_awaddr;
            size_q  <= S_AXI_awsize;
            burst_q <= S_AXI_awburst;
            lock_q  <= S_AXI_awlock[1] ? 2'b00 : S_AXI_awlock;
            cache_q <= S_AXI_awcache;
            prot_q  <= S_AXI_awprot;
            // WRAP cannot be split; oversize WRAP lengths are clipped to one sub-burst.
            if (S_AXI_awburst == B_WRAP && {1'b0, S_AXI_awlen} >= MAXB)
              rem_q <= MAXB;
            else
              rem_q <= {1'b0, S_AXI_awlen} + RW'(1);
          end
        end
        ISSUE: begin
          if (M_AXI_awready) begin
            rem_q <= rem_q - beats;
            if (last) state <= IDLE;
            else if (burst_q == B_INCR)
              addr_q <= addr_q + (ADDR_WIDTH'(beats) << size_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_fixed;
  assign unused_fixed = (B_FIXED == 2'b00);
endmodule

// File: tb/tb_axi_burst_splitter.sv
// Randomised bench for axi_burst_splitter against a queue-based model of the splitting rules.
module tb_axi_burst_splitter;
  logic        ACLK, ARESET;
  logic [3:0]  S_AXI_awid;
  logic [31:0] S_AXI_awaddr;
  logic [7:0]  S_AXI_awlen;
  logic [2:0]  S_AXI_awsize;
  logic [1:0]  S_AXI_awburst, S_AXI_awlock;
  logic [3:0]  S_AXI_awcache;
  logic [2:0]  S_AXI_awprot;
  logic        S_AXI_awvalid, S_AXI_awready;
  logic [3:0]  M_AXI_awid;
  logic [31:0] M_AXI_awaddr;
  logic [3:0]  M_AXI_awlen;
  logic [2:0]  M_AXI_awsize;
  logic [1:0]  M_AXI_awburst, M_AXI_awlock;
  logic [3:0]  M_AXI_awcache;
  logic [2:0]  M_AXI_awprot;
  logic        M_AXI_awvalid, M_AXI_awready, M_Last_Sub, Busy;

  axi_burst_splitter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_awid(S_AXI_awid), .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen),
    .S_AXI_awsize(S_AXI_awsize), .S_AXI_awburst(S_AXI_awburst), .S_AXI_awlock(S_AXI_awlock),
    .S_AXI_awcache(S_AXI_awcache), .S_AXI_awprot(S_AXI_awprot),
    .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
    .M_AXI_awid(M_AXI_awid), .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen),
    .M_AXI_awsize(M_AXI_awsize), .M_AXI_awburst(M_AXI_awburst), .M_AXI_awlock(M_AXI_awlock),
    .M_AXI_awcache(M_AXI_awcache), .M_AXI_awprot(M_AXI_awprot),
    .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_Last_Sub(M_Last_Sub), .Busy(Busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    int          len;
    bit          last;
  } sub_t;

  sub_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input int len, input bit last);
    sub_t s;
    s.addr = a; s.len = len; s.last = last;
    exp_q.push_back(s);
  endtask

  // Reference: walk the request beat budget, cutting at 16 beats (and at 4 KB when enabled).
  task automatic model(input logic [31:0] a0, input int len, input int size, input logic [1:0] burst);
    logic [31:0] a;
    int rem, n, room;
    exp_q.delete();
    a = a0;
    if (burst == 2'b10) begin
      push_exp(a, (len > 15) ? 15 : len, 1'b1);
      return;
    end
    rem = len + 1;
    while (rem > 0) begin
      n = (rem < 16) ? rem : 16;
`ifdef AXI_SPLIT_4K_BOUNDARY_EN
      if (burst == 2'b01) begin
        room = (4096 - int'(a % 4096)) >> size;
        if (room == 0) room = 1;
        if (n > room) n = room;
      end
`else
      room = 0;
`endif
      rem -= n;
      push_exp(a, n - 1, rem == 0);
      if (burst == 2'b01) a = a + 32'(n << size);
    end
  endtask

  // Presents one request and checks every sub-burst against exp_q (filled by caller or model).
  task automatic do_req(input string nm, input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input logic [1:0] lock,
                        input logic [3:0] cache, input logic [2:0] prot, input int stall,
                        input bit rnd_rdy, input bit use_model);
    logic [1:0] e_lock;
    bit rdy;
    int cyc;
    if (use_model) model(a, int'(len), int'(size), burst);
    e_lock = lock[1] ? 2'b00 : lock;
    @(negedge ACLK);
    S_AXI_awid = id; S_AXI_awaddr = a; S_AXI_awlen = len; S_AXI_awsize = size;
    S_AXI_awburst = burst; S_AXI_awlock = lock; S_AXI_awcache = cache; S_AXI_awprot = prot;
    S_AXI_awvalid = 1'b1; M_AXI_awready = 1'b0;
    #1 chk({nm, " s_ready_idle"}, S_AXI_awready, 1);
    @(negedge ACLK);
    S_AXI_awvalid = 1'b0;
    S_AXI_awid = 4'($urandom); S_AXI_awaddr = $urandom; S_AXI_awlen = 8'($urandom);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      rdy = (cyc < stall) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      M_AXI_awready = rdy;
      #1;
      chk({nm, " m_valid"}, M_AXI_awvalid, 1);
      chk({nm, " s_ready_issue"}, S_AXI_awready, 0);
      chk({nm, " busy"}, Busy, 1);
      chk({nm, " addr"}, M_AXI_awaddr, exp_q[0].addr);
      chk({nm, " len"}, M_AXI_awlen, 64'(exp_q[0].len));
      chk({nm, " last"}, M_Last_Sub, exp_q[0].last);
      chk({nm, " attrs"}, {M_AXI_awid, M_AXI_awsize, M_AXI_awburst, M_AXI_awlock, M_AXI_awcache, M_AXI_awprot},
          {id, size, burst, e_lock, cache, prot});
      if (rdy) void'(exp_q.pop_front());
      cyc++;
      @(negedge ACLK);
    end
    chk({nm, " subs_left"}, exp_q.size(), 0);
    M_AXI_awready = 1'b0;
    #1;
    chk({nm, " idle_busy"}, Busy, 0);
    chk({nm, " idle_valid"}, M_AXI_awvalid, 0);
    chk({nm, " idle_s_ready"}, S_AXI_awready, 1);
  endtask

  initial begin
    ARESET = 1'b1; S_AXI_awvalid = 1'b0; M_AXI_awready = 1'b0;
    S_AXI_awid = '0; S_AXI_awaddr = '0; S_AXI_awlen = '0; S_AXI_awsize = '0;
    S_AXI_awburst = '0; S_AXI_awlock = '0; S_AXI_awcache = '0; S_AXI_awprot = '0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    chk("rst s_ready", S_AXI_awready, 0);
    chk("rst m_valid", M_AXI_awvalid, 0);
    chk("rst busy", Busy, 0);
    chk("rst last", M_Last_Sub, 0);
    chk("rst m_fields", {M_AXI_awid, M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst,
                         M_AXI_awlock, M_AXI_awcache, M_AXI_awprot}, 0);
    ARESET = 1'b0;
    #1 chk("rst release s_ready", S_AXI_awready, 1);

    // Directed cases with hand-written expectations.
    exp_q.delete();
    push_exp(32'h1000, 15, 0); push_exp(32'h1040, 15, 0); push_exp(32'h1080, 7, 1);
    do_req("incr40", 4'h3, 32'h1000, 8'd39, 3'd2, 2'b01, 2'b01, 4'h5, 3'h2, 0, 0, 0);
    exp_q.delete();
    push_exp(32'h2000, 15, 1);
    do_req("incr16", 4'h1, 32'h2000, 8'd15, 3'd2, 2'b01, 2'b00, 4'h3, 3'h1, 0, 0, 0);
    exp_q.delete();
    push_exp(32'h200, 15, 0); push_exp(32'h200, 15, 0); push_exp(32'h200, 1, 1);
    do_req("fixed34", 4'h7, 32'h200, 8'd33, 3'd3, 2'b00, 2'b10, 4'hf, 3'h7, 0, 0, 0);
    exp_q.delete();
    push_exp(32'h4000, 15, 0); push_exp(32'h4040, 3, 1);
    do_req("stall5", 4'h9, 32'h4000, 8'd19, 3'd2, 2'b01, 2'b11, 4'h0, 3'h0, 5, 0, 0);
    exp_q.delete();
    push_exp(32'h5004, 15, 1);
    do_req("wrap_trunc", 4'h2, 32'h5004, 8'd20, 3'd2, 2'b10, 2'b01, 4'h2, 3'h4, 0, 0, 0);
    exp_q.delete();
`ifdef AXI_SPLIT_4K_BOUNDARY_EN
    push_exp(32'h0FF8, 1, 0); push_exp(32'h1000, 13, 1);
`else
    push_exp(32'h0FF8, 15, 1);
`endif
    do_req("bnd4k", 4'h4, 32'h0FF8, 8'd15, 3'd2, 2'b01, 2'b00, 4'h1, 3'h3, 0, 0, 0);
    exp_q.delete();
    push_exp(32'hFFFF_FFC0, 15, 0); push_exp(32'h0000_0000, 0, 1);
`ifndef AXI_SPLIT_4K_BOUNDARY_EN
    do_req("addr_wrap", 4'h6, 32'hFFFF_FFC0, 8'd16, 3'd2, 2'b01, 2'b00, 4'h1, 3'h3, 0, 0, 0);
`else
    do_req("addr_wrap", 4'h6, 32'hFFFF_FFC0, 8'd16, 3'd2, 2'b01, 2'b00, 4'h1, 3'h3, 0, 0, 0);
`endif

    // Reset in the middle of a 64-beat request.
    @(negedge ACLK);
    S_AXI_awid = 4'h5; S_AXI_awaddr = 32'h3000; S_AXI_awlen = 8'd63; S_AXI_awsize = 3'd2;
    S_AXI_awburst = 2'b01; S_AXI_awlock = 2'b00; S_AXI_awvalid = 1'b1;
    @(negedge ACLK);
    S_AXI_awvalid = 1'b0; M_AXI_awready = 1'b1;
    #1;
    chk("rstmid first addr", M_AXI_awaddr, 32'h3000);
    chk("rstmid first len", M_AXI_awlen, 15);
    @(negedge ACLK);
    ARESET = 1'b1; M_AXI_awready = 1'b0;
    #1 chk("rstmid s_ready in reset", S_AXI_awready, 0);
    @(negedge ACLK);
    #1;
    chk("rstmid m_valid", M_AXI_awvalid, 0);
    chk("rstmid busy", Busy, 0);
    chk("rstmid addr", M_AXI_awaddr, 0);
    ARESET = 1'b0; M_AXI_awready = 1'b1;
    #1 chk("rstmid s_ready after", S_AXI_awready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      #1 chk("rstmid no more subs", M_AXI_awvalid, 0);
    end
    M_AXI_awready = 1'b0;

    // Randomised requests with random downstream backpressure.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] len;
      len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      do_req("rand", 4'($urandom), $urandom, len, 3'($urandom_range(0, 2)),
             2'($urandom_range(0, 2)), 2'($urandom), 4'($urandom), 3'($urandom),
             $urandom_range(0, 2), 1, 1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge ACLK);
        #1 chk("rand gap s_ready", S_AXI_awready, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
